// File: rtl/compare_result_filter_pkg.sv
// rtl/compare_result_filter_pkg.sv - relation encodings and comparator flag decode
// Shared by the comparator result filter and its run counter.
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_UNKNOWN = 2'b00,
      ST_GT      = 2'b01,
      ST_LT      = 2'b10,
      ST_EQ      = 2'b11
   } state_e;

   typedef struct packed {
      logic   legal;
      state_e st;
   } sample_t;

   function automatic sample_t decode_flags(input logic gt, input logic lt, input logic eq);
      sample_t s;
      s.legal = 1'b1;
      s.st    = ST_UNKNOWN;
      case ({gt, lt, eq})
         3'b100:  s.st = ST_GT;
         3'b010:  s.st = ST_LT;
         3'b001:  s.st = ST_EQ;
         default: s.legal = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/compare_result_filter_if.sv
// rtl/compare_result_filter_if.sv - flag inputs and filtered outputs of the result filter
// master drives comparator flags and clear; slave is the filter.
interface compare_result_filter_if #(
   parameter int EVT_W = 8
);
   logic             clear;
   logic             in_valid;
   logic             a_gt_b;
   logic             a_lt_b;
   logic             a_eq_b;
   logic [1:0]       out_state;
   logic             out_valid;
   logic             change_evt;
   logic             err;
   logic [EVT_W-1:0] evt_count;

   modport master (
      output clear, in_valid, a_gt_b, a_lt_b, a_eq_b,
      input  out_state, out_valid, change_evt, err, evt_count
   );

   modport slave (
      input  clear, in_valid, a_gt_b, a_lt_b, a_eq_b,
      output out_state, out_valid, change_evt, err, evt_count
   );
endinterface

// File: rtl/compare_result_filter_run_counter.sv
// rtl/compare_result_filter_run_counter.sv - candidate relation and saturating run length
// Exposes post-edge candidate and run==HOLD so the commit lands on the same edge.
module cmp_run_counter
   import cmp_pkg::*;
#(
   parameter int HOLD  = 3,
   parameter int CNT_W = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   clear,
   input  logic   sample_en,
   input  state_e sample,
   input  logic   restart,
   output state_e cand_nxt,
   output logic   at_hold_nxt
);
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

   state_e           cand_q, cand_d;
   logic [CNT_W-1:0] run_q, run_d;

   always_comb begin
      cand_d = cand_q;
      run_d  = run_q;
      if (clear || restart) begin
         cand_d = ST_UNKNOWN;
         run_d  = '0;
      end else if (sample_en) begin
         if (sample == cand_q) begin
            if (run_q != HOLD_C) run_d = run_q + 1'b1;
         end else begin
            cand_d = sample;
            run_d  = CNT_W'(1);
         end
      end
   end

   assign cand_nxt    = cand_d;
   assign at_hold_nxt = (run_d == HOLD_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q <= ST_UNKNOWN;
         run_q  <= '0;
      end else begin
         cand_q <= cand_d;
         run_q  <= run_d;
      end
   end
endmodule

// File: rtl/compare_result_filter.sv
// rtl/compare_result_filter.sv - debounced comparator relation with change events
// Define CMP_FILT_STICKY_ERR_EN to hold err until rst/clear instead of pulsing it.
module compare_result_filter
   import cmp_pkg::*;
#(
   parameter int HOLD  = 3,
   parameter int CNT_W = 4,
   parameter int EVT_W = 8
) (
   input logic                    clk,
   input logic                    rst,
   compare_result_filter_if.slave bus
);
   sample_t          smp;
   logic             sample_en, illegal, at_hold_nxt;
   state_e           cand_nxt;

   state_e           out_state_q, out_state_d;
   logic             out_valid_q, out_valid_d;
   logic             change_evt_q, change_evt_d;
   logic             err_q, err_d;
   logic [EVT_W-1:0] evt_count_q, evt_count_d;

   assign smp       = decode_flags(bus.a_gt_b, bus.a_lt_b, bus.a_eq_b);
   assign sample_en = bus.in_valid & smp.legal;
   assign illegal   = bus.in_valid & ~smp.legal;

   cmp_run_counter #(.HOLD(HOLD), .CNT_W(CNT_W)) u_run (
      .clk         (clk),
      .rst         (rst),
      .clear       (bus.clear),
      .sample_en   (sample_en),
      .sample      (smp.st),
      .restart     (illegal),
      .cand_nxt    (cand_nxt),
      .at_hold_nxt (at_hold_nxt)
   );

   always_comb begin
      out_state_d  = out_state_q;
      change_evt_d = 1'b0;
      evt_count_d  = evt_count_q;
`ifdef CMP_FILT_STICKY_ERR_EN
      err_d        = err_q | illegal;
`else
      err_d        = illegal;
`endif
      if (bus.clear) begin
         out_state_d = ST_UNKNOWN;
         evt_count_d = '0;
         err_d       = 1'b0;
      end else if (sample_en && at_hold_nxt && (cand_nxt != out_state_q)) begin
         out_state_d  = cand_nxt;
         change_evt_d = 1'b1;
         if (evt_count_q != '1) evt_count_d = evt_count_q + 1'b1;
      end
      out_valid_d = (out_state_d != ST_UNKNOWN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_state_q  <= ST_UNKNOWN;
         out_valid_q  <= 1'b0;
         change_evt_q <= 1'b0;
         err_q        <= 1'b0;
         evt_count_q  <= '0;
      end else begin
         out_state_q  <= out_state_d;
         out_valid_q  <= out_valid_d;
         change_evt_q <= change_evt_d;
         err_q        <= err_d;
         evt_count_q  <= evt_count_d;
      end
   end

   assign bus.out_state  = out_state_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.change_evt = change_evt_q;
   assign bus.err        = err_q;
   assign bus.evt_count  = evt_count_q;
endmodule
